// File: rtl/latch_bank.sv
// latch_bank: CHANNELS independent WIDTH-bit channels. Each channel has a
// staging register and a held register. Writes land in staging and set the
// channel's dirty flag. A commit strobe copies every dirty channel into its
// held register on one edge, so downstream logic never sees a partly updated
// multi-channel value. dout is driven from the held registers only.
//
// Optional feature, compiled in with `define LATCH_BANK_READBACK_EN:
// adds rd_sel/rd_data, a registered readback of the staging registers with
// one cycle of latency. Out-of-range rd_sel reads 0.
module latch_bank #(
    parameter int               WIDTH      = 8,
    parameter int               CHANNELS   = 4,
    parameter bit               INVERT_OUT = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int               CNT_W      = 8,
    localparam int              AW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_n,
    input  logic [AW-1:0]             wr_sel,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       dirty,
    output logic                      commit_done,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          commit_cnt
`ifdef LATCH_BANK_READBACK_EN
    ,
    input  logic [AW-1:0]             rd_sel,
    output logic [WIDTH-1:0]          rd_data
`endif
);

    // One past the last valid channel index, in AW+1 bits so that a full
    // power-of-two bank (CHANNELS == 2**AW) is still representable.
    localparam logic [AW:0] CH_LIM = CHANNELS[AW:0];

    logic [WIDTH-1:0]    stage_q [CHANNELS];
    logic [WIDTH-1:0]    stage_d [CHANNELS];
    logic [WIDTH-1:0]    held_q  [CHANNELS];
    logic [WIDTH-1:0]    held_d  [CHANNELS];
    logic [CHANNELS-1:0] dirty_q;
    logic [CHANNELS-1:0] dirty_d;
    logic                commit_done_q;
    logic                commit_done_d;
    logic                sel_err_q;
    logic                sel_err_d;
    logic [CNT_W-1:0]    commit_cnt_q;
    logic [CNT_W-1:0]    commit_cnt_d;

    logic                sel_ok;
    logic                wr_ok;

    assign sel_ok = ({1'b0, wr_sel} < CH_LIM);
    assign wr_ok  = !load_n && sel_ok;

    // Next-state: stage the write, then let a commit publish every pending
    // channel, including one written on this same edge.
    always_comb begin
        // NOTE: every combinational output is given a default first so that
        // no path through the block leaves it unassigned (no latch).
        stage_d       = stage_q;
        held_d        = held_q;
        dirty_d       = dirty_q;
        commit_done_d = commit;
        sel_err_d     = !load_n && !sel_ok;
        commit_cnt_d  = commit_cnt_q;

        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_ok && (wr_sel == AW'(i))) begin
                stage_d[i] = wr_data;
                dirty_d[i] = 1'b1;
            end
        end

        if (commit) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (dirty_d[i]) begin
                    held_d[i] = stage_d[i];
                end
            end
            dirty_d      = '0;
            commit_cnt_d = commit_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards staged data and pending pulses at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the staging/held arrays are a few flops per channel, not a
            // RAM, so they are reset to RESET_VAL like any other register.
            for (int i = 0; i < CHANNELS; i++) begin
                stage_q[i] <= RESET_VAL;
                held_q[i]  <= RESET_VAL;
            end
            dirty_q       <= '0;
            commit_done_q <= 1'b0;
            sel_err_q     <= 1'b0;
            commit_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            for (int i = 0; i < CHANNELS; i++) begin
                stage_q[i] <= stage_d[i];
                held_q[i]  <= held_d[i];
            end
            dirty_q       <= dirty_d;
            commit_done_q <= commit_done_d;
            sel_err_q     <= sel_err_d;
            commit_cnt_q  <= commit_cnt_d;
        end
    end

    // Output view of the held registers, optionally inverted per channel.
    always_comb begin
        dout = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            dout[i*WIDTH +: WIDTH] = INVERT_OUT ? ~held_q[i] : held_q[i];
        end
    end

    assign dirty       = dirty_q;
    assign commit_done = commit_done_q;
    assign sel_err     = sel_err_q;
    assign commit_cnt  = commit_cnt_q;

`ifdef LATCH_BANK_READBACK_EN
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Readback select: current staging content, so a same-edge write shows
    // up one read cycle later.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_sel == AW'(i)) begin
                rd_data_d = stage_q[i];
            end
        end
    end

    // Readback register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_latch_bank.sv
// Testbench for latch_bank. Two instances share one stimulus stream:
//   a: WIDTH=8, CHANNELS=4, INVERT_OUT=1, RESET_VAL=0,     CNT_W=8
//   b: WIDTH=8, CHANNELS=3, INVERT_OUT=0, RESET_VAL=8'h3C, CNT_W=2
// A transaction-level model per instance is checked every cycle on the
// falling edge; directed literal checks pin the model to hand-worked values.
module tb_latch_bank;

    logic        clk;
    logic        rst_n;
    logic        load_n;
    logic [1:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        commit;

    logic [31:0] dout_a;
    logic [3:0]  dirty_a;
    logic        done_a, err_a;
    logic [7:0]  cnt_a;
    logic [23:0] dout_b;
    logic [2:0]  dirty_b;
    logic        done_b, err_b;
    logic [1:0]  cnt_b;
`ifdef LATCH_BANK_READBACK_EN
    logic [1:0]  rd_sel;
    logic [7:0]  rd_a, rd_b;
`endif

    int checks   = 0;
    int failures = 0;
    bit running  = 0;

    latch_bank #(.WIDTH(8), .CHANNELS(4), .INVERT_OUT(1'b1), .RESET_VAL(8'h00), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .wr_sel(wr_sel), .wr_data(wr_data),
        .commit(commit), .dout(dout_a), .dirty(dirty_a), .commit_done(done_a),
        .sel_err(err_a), .commit_cnt(cnt_a)
`ifdef LATCH_BANK_READBACK_EN
        , .rd_sel(rd_sel), .rd_data(rd_a)
`endif
    );

    latch_bank #(.WIDTH(8), .CHANNELS(3), .INVERT_OUT(1'b0), .RESET_VAL(8'h3C), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .wr_sel(wr_sel), .wr_data(wr_data),
        .commit(commit), .dout(dout_b), .dirty(dirty_b), .commit_done(done_b),
        .sel_err(err_b), .commit_cnt(cnt_b)
`ifdef LATCH_BANK_READBACK_EN
        , .rd_sel(rd_sel), .rd_data(rd_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int       m_ch   [2] = '{4, 3};
    bit       m_inv  [2] = '{1'b1, 1'b0};
    int       m_cntw [2] = '{8, 2};
    logic [7:0] m_rst [2] = '{8'h00, 8'h3C};
    logic [7:0] m_stage [2][4];
    logic [7:0] m_held  [2][4];
    bit         m_dirty [2][4];
    bit         m_done  [2];
    bit         m_err   [2];
    int         m_cnt   [2];
    logic [7:0] m_rd    [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_stage[k][i] = m_rst[k];
                m_held[k][i]  = m_rst[k];
                m_dirty[k][i] = 1'b0;
            end
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
            m_cnt[k]  = 0;
            m_rd[k]   = 8'h00;
        end
    endtask

    // Apply one rising edge worth of the bank's rules to instance k.
    task automatic model_step(int k);
        int  sel = int'(wr_sel);
        bit  in_range = (sel < m_ch[k]);
`ifdef LATCH_BANK_READBACK_EN
        m_rd[k] = (int'(rd_sel) < m_ch[k]) ? m_stage[k][rd_sel] : 8'h00;
`endif
        m_err[k]  = !load_n && !in_range;
        m_done[k] = commit;
        if (!load_n && in_range) begin
            m_stage[k][sel] = wr_data;
            m_dirty[k][sel] = 1'b1;
        end
        if (commit) begin
            m_cnt[k] = (m_cnt[k] + 1) % (1 << m_cntw[k]);
            for (int i = 0; i < m_ch[k]; i++) begin
                if (m_dirty[k][i]) m_held[k][i] = m_stage[k][i];
                m_dirty[k][i] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] exp_dout(int k);
        logic [31:0] r = '0;
        for (int i = 0; i < m_ch[k]; i++)
            r[i*8 +: 8] = m_inv[k] ? ~m_held[k][i] : m_held[k][i];
        return r;
    endfunction

    function automatic logic [31:0] exp_dirty(int k);
        logic [31:0] r = '0;
        for (int i = 0; i < m_ch[k]; i++) r[i] = m_dirty[k][i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (running) begin
            check("a_dout",  dout_a,               exp_dout(0));
            check("a_dirty", {28'h0, dirty_a},     exp_dirty(0));
            check("a_done",  {31'h0, done_a},      {31'h0, m_done[0]});
            check("a_err",   {31'h0, err_a},       {31'h0, m_err[0]});
            check("a_cnt",   {24'h0, cnt_a},       m_cnt[0]);
            check("b_dout",  {8'h0, dout_b},       exp_dout(1));
            check("b_dirty", {29'h0, dirty_b},     exp_dirty(1));
            check("b_done",  {31'h0, done_b},      {31'h0, m_done[1]});
            check("b_err",   {31'h0, err_b},       {31'h0, m_err[1]});
            check("b_cnt",   {30'h0, cnt_b},       m_cnt[1]);
`ifdef LATCH_BANK_READBACK_EN
            check("a_rd",    {24'h0, rd_a},        {24'h0, m_rd[0]});
            check("b_rd",    {24'h0, rd_b},        {24'h0, m_rd[1]});
`endif
        end
    end

    // One clock: drive inputs, take the edge, advance the model, settle.
    task automatic cyc(input logic ld_n, input logic [1:0] sel, input logic [7:0] data, input logic cm);
        load_n  = ld_n;
        wr_sel  = sel;
        wr_data = data;
        commit  = cm;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        load_n  = 1'b1;
        wr_sel  = 2'd0;
        wr_data = 8'h00;
        commit  = 1'b0;
`ifdef LATCH_BANK_READBACK_EN
        rd_sel  = 2'd2;
`endif
        model_reset();
        running = 1'b1;
        #12;
        rst_n = 1'b1;

        // Reset state.
        check("rst_a_dout",  dout_a, 32'hFFFF_FFFF);
        check("rst_a_dirty", {28'h0, dirty_a}, 32'h0);
        check("rst_a_cnt",   {24'h0, cnt_a}, 32'h0);
        check("rst_b_dout",  {8'h0, dout_b}, 32'h003C_3C3C);

        // Staging isolation, then commit.
        cyc(1'b0, 2'd2, 8'h5A, 1'b0);
        check("stage_a_dirty", {28'h0, dirty_a}, 32'h4);
        check("stage_a_dout",  dout_a, 32'hFFFF_FFFF);
        cyc(1'b1, 2'd0, 8'h00, 1'b1);
        check("commit_a_dout", dout_a, 32'hFFA5_FFFF);
        check("commit_a_done", {31'h0, done_a}, 32'h1);
        check("commit_a_cnt",  {24'h0, cnt_a}, 32'h1);
        check("commit_b_dout", {8'h0, dout_b}, 32'h005A_3C3C);
        cyc(1'b1, 2'd0, 8'h00, 1'b0);
        check("done_pulse_end", {31'h0, done_a}, 32'h0);

        // Atomic multi-channel commit; ch3 is out of range for b.
        cyc(1'b0, 2'd0, 8'h11, 1'b0);
        cyc(1'b0, 2'd3, 8'h33, 1'b0);
        check("oor_b_err",   {31'h0, err_b}, 32'h1);
        check("oor_b_dirty", {29'h0, dirty_b}, 32'h1);
        check("oor_a_dirty", {28'h0, dirty_a}, 32'h9);
        cyc(1'b0, 2'd1, 8'h22, 1'b1);
        check("atomic_a_dout",  dout_a, 32'hCCA5_DDEE);
        check("atomic_a_dirty", {28'h0, dirty_a}, 32'h0);
        check("atomic_b_dout",  {8'h0, dout_b}, 32'h005A_2211);
        check("oor_b_err_end",  {31'h0, err_b}, 32'h0);

        // Last write wins; idle hold; commit.
        cyc(1'b0, 2'd0, 8'h01, 1'b0);
        cyc(1'b0, 2'd0, 8'h02, 1'b0);
        cyc(1'b1, 2'd0, 8'h00, 1'b0);
        check("hold_a_dout", dout_a, 32'hCCA5_DDEE);
        cyc(1'b1, 2'd0, 8'h00, 1'b1);
        check("lastwin_a_dout", dout_a, 32'hCCA5_DDFD);
        check("lastwin_b_dout", {8'h0, dout_b}, 32'h005A_2202);

        // Commit with nothing dirty: dout holds, counters advance (b wraps).
        cyc(1'b1, 2'd0, 8'h00, 1'b1);
        check("empty_a_dout", dout_a, 32'hCCA5_DDFD);
        check("empty_a_cnt",  {24'h0, cnt_a}, 32'h4);
        check("empty_b_cnt",  {30'h0, cnt_b}, 32'h0);

        // Reset mid-operation, asserted between edges.
        cyc(1'b0, 2'd1, 8'h77, 1'b0);
        check("pre_rst_a_dirty", {28'h0, dirty_a}, 32'h2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_a_dirty", {28'h0, dirty_a}, 32'h0);
        check("mid_rst_a_dout",  dout_a, 32'hFFFF_FFFF);
        check("mid_rst_b_dout",  {8'h0, dout_b}, 32'h003C_3C3C);
        check("mid_rst_a_cnt",   {24'h0, cnt_a}, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back commits after release; b counter walks 1,2,3,0.
        cyc(1'b1, 2'd0, 8'h00, 1'b1);
        check("post_rst_a_dout", dout_a, 32'hFFFF_FFFF);
        check("wrap_b_cnt1", {30'h0, cnt_b}, 32'h1);
        cyc(1'b1, 2'd0, 8'h00, 1'b1);
        check("wrap_b_cnt2", {30'h0, cnt_b}, 32'h2);
        cyc(1'b1, 2'd0, 8'h00, 1'b1);
        check("wrap_b_cnt3", {30'h0, cnt_b}, 32'h3);
        cyc(1'b1, 2'd0, 8'h00, 1'b1);
        check("wrap_b_cnt0", {30'h0, cnt_b}, 32'h0);
        check("b2b_a_done",  {31'h0, done_a}, 32'h1);
        check("b2b_a_cnt",   {24'h0, cnt_a}, 32'h4);
        check("b2b_b_dout",  {8'h0, dout_b}, 32'h003C_3C3C);

        cyc(1'b1, 2'd0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/latch_bank.md
Name: latch_bank

Overview:
- Parametrised, clocked successor to the single-bit load latch.
- CHANNELS independent WIDTH-bit storage channels, each with a staging register and a held (output) register.
- Writes land in staging. A commit strobe atomically transfers every dirty channel to its held register, so all outputs change on the same edge.
- Sits between a config/control writer and downstream logic that must never see a partially updated multi-channel value.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- CHANNELS, 4, number of channels (>=1).
- INVERT_OUT, 1, 1: dout drives the inverted held value; 0: true value.
- RESET_VAL, 0, WIDTH-bit value loaded into stage and held registers on reset.
- CNT_W, 8, width of the commit counter.
- Derived: AW = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_n  in  1  active-low write enable for the staging registers.
- wr_sel  in  AW  target channel index.
- wr_data  in  WIDTH  write data.
- commit  in  1  commit strobe, sampled each rising edge.
- dout  out  CHANNELS*WIDTH  held values; channel i occupies [i*WIDTH +: WIDTH].
- dirty  out  CHANNELS  staged-but-uncommitted flag per channel.
- commit_done  out  1  one-cycle pulse following a sampled commit.
- sel_err  out  1  one-cycle pulse following an out-of-range write.
- commit_cnt  out  CNT_W  number of commits since reset, wraps.

Behaviour:
- Reset (async assert, sync-safe release):
  - All stage and held registers are set to RESET_VAL.
  - dirty=0, commit_done=0, sel_err=0, commit_cnt=0.
  - dout = INVERT_OUT ? ~RESET_VAL : RESET_VAL per channel.
  - Reset asserted mid-operation discards all staged data and pending pulses immediately.
- Write, on an edge with load_n=0 and wr_sel<CHANNELS:
  - stage[wr_sel] <= wr_data and dirty[wr_sel] <= 1.
  - Repeated writes to a dirty channel overwrite; the last write wins.
- Out-of-range write (load_n=0, wr_sel>=CHANNELS): no storage change; sel_err=1 for exactly the next cycle.
- Commit, on an edge with commit=1:
  - For every channel with dirty=1, held <= stage; dirty is cleared.
  - Clean channels keep their held value.
  - commit_done=1 for the following cycle.
  - commit_cnt increments, wrapping 2^CNT_W-1 -> 0.
- Commit with no dirty channels: held registers unchanged; commit_done still pulses and commit_cnt still increments.
- Simultaneous write and commit on the same edge:
  - The written data is included in that commit, so held[wr_sel] <= wr_data.
  - dirty[wr_sel] ends at 0.
  - Other dirty channels commit their staged data.
- Latency:
  - Write to stage: 1 edge.
  - Commit to dout: dout reflects the new held values in the cycle immediately after the commit edge.
  - dout is combinational from the held registers only, never from stage.
- Back-to-back commits on consecutive cycles: commit_done stays high and commit_cnt increments each cycle.
- load_n=1 with commit=0: all state holds.

Optional Feature:
- Macro: LATCH_BANK_READBACK_EN.
- Enabled: adds two ports.
  - rd_sel (in, AW).
  - rd_data (out, WIDTH): the registered stage[rd_sel] value with 1-cycle latency.
  - rd_data reads 0 for out-of-range rd_sel and resets to 0.
  - A same-edge write is not visible on rd_data until the following read cycle.
- Disabled: the ports and readback register are absent; all other behaviour is identical.

Test Plan:
- Reset: WIDTH=8, CHANNELS=4, INVERT_OUT=1, RESET_VAL=0 -> dout=32'hFFFF_FFFF, dirty=0, commit_cnt=0.
- Staging isolation: write ch2=8'h5A with load_n=0 -> dirty=4'b0100 and dout unchanged. Commit -> next cycle dout[23:16]=8'hA5, dirty=0, commit_done pulses, commit_cnt=1.
- Atomic multi-channel commit: write ch0=8'h11 and ch3=8'h33, then in the same cycle write ch1=8'h22 with commit=1 -> all three update together (inverted 8'hEE, 8'hDD, 8'hCC); ch2 is unchanged; dirty=0.
- Out-of-range write with CHANNELS=3: write wr_sel=3 -> sel_err pulses one cycle; no dirty bit set; dout unchanged.
- Reset mid-operation: stage ch1 dirty, assert rst_n=0 between edges -> immediately dirty=0 and dout back to the reset value; a commit after release leaves dout unchanged.
- Counter wrap with CNT_W=2: four commits -> commit_cnt sequence 1,2,3,0; INVERT_OUT=0 build -> dout equals the written values directly.
